// File: rtl/alu_pkg.sv
// alu_pkg: ALU codes, ALUOp classes, funct constants, M-op codes and control FSM states
package alu_pkg;
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SLL   = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_LUI   = 4'b1010;
  localparam logic [3:0] ALU_AUIPC = 4'b1011;
  localparam logic [2:0] OP_IL    = 3'd0;
  localparam logic [2:0] OP_B     = 3'd1;
  localparam logic [2:0] OP_R     = 3'd2;
  localparam logic [2:0] OP_I     = 3'd3;
  localparam logic [2:0] OP_LUI   = 3'd4;
  localparam logic [2:0] OP_AUIPC = 3'd5;
  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SR  = 3'd5;
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_M    = 7'h01;
  localparam logic [6:0] F7_ALT  = 7'h20;
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;
  typedef enum logic [1:0] {IDLE, MD_BUSY, MD_DONE} state_t;
  function automatic logic [3:0] f3_op(input logic [2:0] f3);
    case (f3)
      3'd0: f3_op = ALU_ADD;
      3'd1: f3_op = ALU_SLL;
      3'd2: f3_op = ALU_SLT;
      3'd3: f3_op = ALU_SLTU;
      3'd4: f3_op = ALU_XOR;
      3'd5: f3_op = ALU_SRL;
      3'd6: f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational ALUOp/funct3/funct7 to ALU code, M-op and illegal flag
module alu_decode import alu_pkg::*; (
  input  logic [2:0] i_ALUOp,
  input  logic [2:0] i_Funct3,
  input  logic [6:0] i_Funct7,
  output logic [3:0] o_ctl,
  output logic [2:0] o_md_op,
  output logic       o_is_md,
  output logic       o_illegal
);
  always_comb begin
    o_ctl = ALU_ADD;
    o_md_op = 3'd0;
    o_is_md = 1'b0;
    o_illegal = 1'b0;
    case (i_ALUOp)
      OP_IL: o_ctl = ALU_ADD;
      OP_B: o_ctl = ALU_SUB;
      OP_LUI: o_ctl = ALU_LUI;
      OP_AUIPC: o_ctl = ALU_AUIPC;
      OP_R:
        if (i_Funct7 == F7_BASE) o_ctl = f3_op(i_Funct3);
        else if (i_Funct7 == F7_ALT && i_Funct3 == F3_ADD) o_ctl = ALU_SUB;
        else if (i_Funct7 == F7_ALT && i_Funct3 == F3_SR) o_ctl = ALU_SRA;
        else if (i_Funct7 == F7_M) begin
          o_is_md = 1'b1;
          o_md_op = i_Funct3;
        end
        else o_illegal = 1'b1;
      OP_I:
        if (i_Funct3 != F3_SR || i_Funct7 == F7_BASE) o_ctl = f3_op(i_Funct3);
        else if (i_Funct7 == F7_ALT) o_ctl = ALU_SRA;
        else o_illegal = 1'b1;
      default: o_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_md_control.sv
// alu_md_control: registered ALU decode with MUL/DIV occupancy FSM and stall control
module alu_md_control import alu_pkg::*; #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33,
  parameter int CNT_W = 6
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_flush,
  input  logic [2:0] i_ALUOp,
  input  logic [2:0] i_Funct3,
  input  logic [6:0] i_Funct7,
  output logic [3:0] o_ALUControlLines,
  output logic [2:0] o_MDOp,
  output logic       o_valid,
  output logic       o_md_start,
  output logic       o_md_done,
  output logic       o_stall,
  output logic       o_illegal
);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0] w_ctl;
  logic [2:0] w_md_op;
  logic w_is_md, w_illegal;
  alu_decode u_dec (
    .i_ALUOp(i_ALUOp),
    .i_Funct3(i_Funct3),
    .i_Funct7(i_Funct7),
    .o_ctl(w_ctl),
    .o_md_op(w_md_op),
    .o_is_md(w_is_md),
    .o_illegal(w_illegal)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      o_valid <= 1'b0;
      o_md_start <= 1'b0;
      o_md_done <= 1'b0;
      o_stall <= 1'b0;
      o_illegal <= 1'b0;
      o_ALUControlLines <= ALU_ADD;
      o_MDOp <= 3'd0;
    end else if (i_flush) begin
      r_state <= IDLE;
      r_cnt <= '0;
      o_valid <= 1'b0;
      o_md_start <= 1'b0;
      o_md_done <= 1'b0;
      o_stall <= 1'b0;
      o_illegal <= 1'b0;
    end else begin
      o_md_start <= 1'b0;
      o_md_done <= 1'b0;
      if (r_state == MD_BUSY) begin
        if (r_cnt == '0) begin
          r_state <= MD_DONE;
          o_md_done <= 1'b1;
          o_stall <= 1'b0;
        end else r_cnt <= r_cnt - 1'b1;
      end else if (i_valid) begin
        r_state <= w_is_md ? MD_BUSY : IDLE;
        r_cnt <= w_is_md ? (w_md_op[2] ? DIV_CNT : MUL_CNT) : '0;
        o_valid <= 1'b1;
        o_md_start <= w_is_md;
        o_stall <= w_is_md;
        o_illegal <= w_illegal;
        o_ALUControlLines <= w_ctl;
        o_MDOp <= w_md_op;
      end else begin
        r_state <= IDLE;
        o_valid <= 1'b0;
      end
    end
  end
endmodule
